// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing for the two-port data-memory arbiter.
// Optional build macro: DMEM_ARB_RR_EN (round-robin tie-break).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int NUM_PORTS  = 2;
  localparam int DMEM_DEPTH = 64;
  localparam int DMEM_IDX_W = 6;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: o_win = 0 grants port 0, 1 grants port 1.
// DMEM_ARB_RR_EN defined: ties go to the port not granted last; otherwise port 0 wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifdef DMEM_ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_win
);

`ifdef DMEM_ARB_RR_EN
  assign o_win = (i_req1 & ~i_req0) | (i_req0 & i_req1 & ~i_last);
`else
  assign o_win = i_req1 & ~i_req0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two masters onto the single-cycle data memory, one access per 3 cycles.
// Build macro DMEM_ARB_RR_EN selects round-robin tie-break instead of fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_t  r_state;
  logic        r_port;
  logic        r_err;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;
  logic [31:0] r_rdata;
  logic        r_mem_write;
  logic        r_mem_read;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_oor;

`ifdef DMEM_ARB_RR_EN
  logic r_last;

  dmem_arb_pick u_pick (
    .i_req0 (req0),
    .i_req1 (req1),
    .i_last (r_last),
    .o_win  (w_win)
  );
`else
  dmem_arb_pick u_pick (
    .i_req0 (req0),
    .i_req1 (req1),
    .o_win  (w_win)
  );
`endif

  assign w_we    = w_win ? we1    : we0;
  assign w_addr  = w_win ? addr1  : addr0;
  assign w_wdata = w_win ? wdata1 : wdata0;
  assign w_oor   = (w_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_port      <= 1'b0;
      r_err       <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
`ifdef DMEM_ARB_RR_EN
      r_last      <= 1'b0;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_port      <= w_win;
            r_err       <= w_oor;
            r_mem_write <= w_we & ~w_oor;
            r_mem_read  <= ~w_we & ~w_oor;
            r_mem_addr  <= 32'(w_addr);
            r_mem_wdata <= w_wdata;
`ifdef DMEM_ARB_RR_EN
            r_last      <= w_win;
`endif
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_mem_read) r_rdata <= mem_rdata;
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_addr  <= 32'd0;
          r_mem_wdata <= 32'd0;
          r_ack0      <= ~r_port;
          r_ack1      <= r_port;
          r_err0      <= ~r_port & r_err;
          r_err1      <= r_port & r_err;
          r_state     <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by rst_n so a store aborted at its closing edge never commits.
  assign mem_write = r_mem_write & rst_n;
  assign mem_read  = r_mem_read & rst_n;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64x32 data memory.
// Honours DMEM_ARB_RR_EN for the expected tie-break order.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_waddr = 6'd0;
  logic [31:0] tb_wdata = 32'd0;
  logic        overlap_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DEPTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .err0      (err0),
    .err1      (err1),
    .rdata     (rdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end
  assign mem_rdata = mem[mem_addr[5:0]];

  always @(negedge clk) begin
    if (mem_write && mem_read) overlap_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick(); tick();
    checks++;
    if ({ack0, ack1, err0, err1, rdata, mem_write, mem_read, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_in: outputs not zero during reset, rdata=%h addr=%h", rdata, mem_addr);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({ack0, ack1, err0, err1, rdata, mem_write, mem_read, mem_addr, mem_wdata} !== '0) begin
        errors++; $display("FAIL idle_%0d: ack=%b%b err=%b%b wr=%b rd=%b addr=%h, expected all 0",
                           i, ack0, ack1, err0, err1, mem_write, mem_read, mem_addr);
      end
    end
  endtask

  task automatic test_store_load();
    req0 = 1; we0 = 1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
    tick();
    checks++;
    if ({mem_write, mem_read, mem_addr, mem_wdata, ack0} !== {2'b10, 32'd5, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL st_access: wr=%b rd=%b addr=%h wd=%h ack0=%b, expected 1 0 5 deadbeef 0",
                         mem_write, mem_read, mem_addr, mem_wdata, ack0);
    end
    tick();
    checks++;
    if ({ack0, err0, ack1, mem_write, mem_addr} !== {4'b1000, 32'd0} || mem[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL st_ack: ack0=%b err0=%b ack1=%b wr=%b mem5=%h, expected 1 0 0 0 deadbeef",
                         ack0, err0, ack1, mem_write, mem[5]);
    end
    req0 = 0; wdata0 = 0;
    tick();
    checks++;
    if (ack0 !== 1'b0) begin
      errors++; $display("FAIL st_ack_len: ack0=%b, expected 0", ack0);
    end
    req0 = 1; we0 = 0;
    tick();
    checks++;
    if ({mem_write, mem_read, mem_addr} !== {2'b01, 32'd5}) begin
      errors++; $display("FAIL ld_access: wr=%b rd=%b addr=%h, expected 0 1 5", mem_write, mem_read, mem_addr);
    end
    tick();
    checks++;
    if ({ack0, err0} !== 2'b10 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL ld_ack: ack0=%b err0=%b rdata=%h, expected 1 0 deadbeef", ack0, err0, rdata);
    end
    req0 = 0;
    tick();
  endtask

  task automatic test_tie(input logic p1_first);
    logic [31:0] a_first, a_second, d_first, d_second;
    preload(6'd3, 32'h33333333);
    preload(6'd4, 32'h44444444);
    a_first  = p1_first ? 32'd4 : 32'd3;
    a_second = p1_first ? 32'd3 : 32'd4;
    d_first  = p1_first ? 32'h44444444 : 32'h33333333;
    d_second = p1_first ? 32'h33333333 : 32'h44444444;
    req0 = 1; we0 = 0; addr0 = 32'd3;
    req1 = 1; we1 = 0; addr1 = 32'd4;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== a_first) begin
      errors++; $display("FAIL tie_first_addr: rd=%b addr=%h, expected 1 %h", mem_read, mem_addr, a_first);
    end
    tick();
    checks++;
    if ({ack1, ack0} !== (p1_first ? 2'b10 : 2'b01) || rdata !== d_first) begin
      errors++; $display("FAIL tie_first_ack: ack1=%b ack0=%b rdata=%h, expected p1_first=%b data %h",
                         ack1, ack0, rdata, p1_first, d_first);
    end
    if (p1_first) req1 = 0; else req0 = 0;
    tick();
    checks++;
    if ({ack0, ack1, mem_read} !== 3'b000) begin
      errors++; $display("FAIL tie_gap: ack0=%b ack1=%b rd=%b, expected 0 0 0", ack0, ack1, mem_read);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== a_second) begin
      errors++; $display("FAIL tie_second_addr: rd=%b addr=%h, expected 1 %h", mem_read, mem_addr, a_second);
    end
    tick();
    checks++;
    if ({ack1, ack0} !== (p1_first ? 2'b01 : 2'b10) || rdata !== d_second) begin
      errors++; $display("FAIL tie_second_ack: ack1=%b ack0=%b rdata=%h, expected data %h",
                         ack1, ack0, rdata, d_second);
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_out_of_range();
    preload(6'd0, 32'h00001234);
    req1 = 1; we1 = 1; addr1 = 32'd64; wdata1 = 32'hBAD0BAD0;
    tick();
    checks++;
    if ({mem_write, mem_read} !== 2'b00 || mem_addr !== 32'd64) begin
      errors++; $display("FAIL oor_access: wr=%b rd=%b addr=%h, expected 0 0 40", mem_write, mem_read, mem_addr);
    end
    tick();
    checks++;
    if ({ack1, err1, ack0, err0} !== 4'b1100) begin
      errors++; $display("FAIL oor_ack: ack1=%b err1=%b ack0=%b err0=%b, expected 1 1 0 0", ack1, err1, ack0, err0);
    end
    req1 = 0;
    tick();
    req1 = 1; we1 = 0; addr1 = 32'd0;
    tick(); tick();
    checks++;
    if ({ack1, err1} !== 2'b10 || rdata !== 32'h00001234) begin
      errors++; $display("FAIL oor_mem0: ack1=%b err1=%b rdata=%h, expected 1 0 00001234", ack1, err1, rdata);
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_reset_abort();
    preload(6'd7, 32'h07070707);
    req0 = 1; we0 = 1; addr0 = 32'd7; wdata0 = 32'hFFFF0000;
    tick();
    checks++;
    if (mem_write !== 1'b1) begin
      errors++; $display("FAIL abort_access: wr=%b, expected 1", mem_write);
    end
    rst_n = 0;
    tick();
    checks++;
    if ({ack0, err0, mem_write, mem_read} !== 4'b0000 || mem[7] !== 32'h07070707) begin
      errors++; $display("FAIL abort_reset: ack0=%b wr=%b rd=%b mem7=%h, expected 0 0 0 07070707",
                         ack0, mem_write, mem_read, mem[7]);
    end
    req0 = 0; rst_n = 1;
    tick();
    checks++;
    if ({ack0, ack1} !== 2'b00) begin
      errors++; $display("FAIL abort_noack: ack0=%b ack1=%b, expected 0 0", ack0, ack1);
    end
    req0 = 1; we0 = 0;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'd7) begin
      errors++; $display("FAIL abort_idle: rd=%b addr=%h, expected 1 7", mem_read, mem_addr);
    end
    tick();
    checks++;
    if (ack0 !== 1'b1 || rdata !== 32'h07070707) begin
      errors++; $display("FAIL abort_mem7: ack0=%b rdata=%h, expected 1 07070707", ack0, rdata);
    end
    req0 = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    req0 = 1; we0 = 0; addr0 = 32'd5;
    tick(); tick();
    checks++;
    if (ack0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hold_ack1: ack0=%b rdata=%h, expected 1 deadbeef", ack0, rdata);
    end
    tick();
    checks++;
    if ({ack0, mem_read} !== 2'b00) begin
      errors++; $display("FAIL hold_gap: ack0=%b rd=%b, expected 0 0", ack0, mem_read);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1) begin
      errors++; $display("FAIL hold_access2: rd=%b, expected 1", mem_read);
    end
    tick();
    checks++;
    if (ack0 !== 1'b1) begin
      errors++; $display("FAIL hold_ack2: ack0=%b, expected 1", ack0);
    end
    req0 = 0;
    tick();
    checks++;
    if (overlap_seen !== 1'b0) begin
      errors++; $display("FAIL strobe_overlap: seen=%b, expected 0", overlap_seen);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
`ifdef DMEM_ARB_RR_EN
    test_tie(1'b1);
`else
    test_tie(1'b0);
`endif
    test_out_of_range();
    test_tie(1'b0);
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
